// File: rtl/spi_cmd_sequencer_pkg.sv
// rtl/spi_cmd_sequencer_pkg.sv - shared types and constants for the SPI command sequencer
package spi_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RELEASE = 2'd3
    } seq_state_t;

    localparam logic [1:0] SEL_ILLEGAL = 2'd3;
    localparam int         CMD_W       = 10;
    localparam int         RSP_W       = 11;

    // Response record layout: {sel[1:0], data[7:0], err}
    function automatic logic [RSP_W-1:0] pack_rsp(input logic [1:0] sel,
                                                   input logic [7:0] data,
                                                   input logic       err);
        return {sel, data, err};
    endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// rtl/spi_seq_fifo.sv - parameterised synchronous FIFO used for command and response queues
module spi_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign rd_en    = pop && !empty;
    // A push into a full queue is accepted when the head leaves in the same cycle
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - queues SPI byte commands, sequences SPI transfers and returns responses
module spi_cmd_sequencer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_sel,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_sel,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       spi_start,
    output logic [1:0] spi_slaveselect,
    output logic [7:0] spi_master_data,
    input  logic       spi_done,
    input  logic [7:0] spi_master_rx,
    output logic       busy
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    seq_state_t       state_q;
    seq_state_t       state_d;

    logic             cmd_full;
    logic             cmd_empty;
    logic             cmd_push;
    logic             cmd_pop;
    logic [CMD_W-1:0] cmd_head;

    logic             rsp_full;
    logic             rsp_empty;
    logic             rsp_push;
    logic             rsp_pop;
    logic [RSP_W-1:0] rsp_head;

    logic [1:0]       held_sel;
    logic [7:0]       held_data;
    logic [7:0]       rx_q;
    logic             err_q;
    logic [TMO_W-1:0] tmo_cnt;

    logic             load_cmd;
    logic             cap_done;
    logic             cap_tmo;
    logic             cnt_inc;

    // Gating with rst_n keeps the queue closed while reset is held
    assign cmd_ready = rst_n && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;

    spi_seq_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data ({cmd_sel, cmd_data}),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty)
    );

    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    spi_seq_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_push),
        .push_data (pack_rsp(held_sel, rx_q, err_q)),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .full      (rsp_full),
        .empty     (rsp_empty)
    );

    // Storage is not reset, so the head is masked until it holds a real entry
    assign rsp_sel  = rsp_valid ? rsp_head[RSP_W-1 -: 2] : 2'd0;
    assign rsp_data = rsp_valid ? rsp_head[8:1]          : 8'h00;
    assign rsp_err  = rsp_valid ? rsp_head[0]            : 1'b0;

    assign busy = (state_q != ST_IDLE) || !cmd_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cmd_pop         = 1'b0;
        rsp_push        = 1'b0;
        load_cmd        = 1'b0;
        cap_done        = 1'b0;
        cap_tmo         = 1'b0;
        cnt_inc         = 1'b0;
        spi_start       = 1'b0;
        spi_slaveselect = 2'd0;
        spi_master_data = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop  = 1'b1;
                    load_cmd = 1'b1;
                    state_d  = (cmd_head[CMD_W-1 -: 2] == SEL_ILLEGAL) ? ST_CAPTURE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                spi_start       = 1'b1;
                spi_slaveselect = held_sel;
                spi_master_data = held_data;
                if (spi_done) begin
                    cap_done = 1'b1;
                    state_d  = ST_CAPTURE;
                end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                    cap_tmo = 1'b1;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (!rsp_full || rsp_pop) begin
                    rsp_push = 1'b1;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!spi_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Illegal selects are preloaded with the error record so CAPTURE can push directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_sel  <= 2'd0;
            held_data <= 8'h00;
            rx_q      <= 8'h00;
            err_q     <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (load_cmd) begin
                held_sel  <= cmd_head[CMD_W-1 -: 2];
                held_data <= cmd_head[7:0];
                rx_q      <= 8'h00;
                err_q     <= (cmd_head[CMD_W-1 -: 2] == SEL_ILLEGAL);
                tmo_cnt   <= '0;
            end
            if (cap_done) begin
                rx_q  <= spi_master_rx;
                err_q <= 1'b0;
            end
            if (cap_tmo) begin
                rx_q  <= 8'h00;
                err_q <= 1'b1;
            end
            if (cnt_inc) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - scoreboard bench for spi_cmd_sequencer with a simple SPI slave model
module tb_spi_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_sel;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       spi_start;
    logic [1:0] spi_slaveselect;
    logic [7:0] spi_master_data;
    logic       spi_done;
    logic [7:0] spi_master_rx;
    logic       busy;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(
        .CMD_DEPTH (4),
        .RSP_DEPTH (4),
        .TIMEOUT   (15)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_sel         (cmd_sel),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_sel         (rsp_sel),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .spi_start       (spi_start),
        .spi_slaveselect (spi_slaveselect),
        .spi_master_data (spi_master_data),
        .spi_done        (spi_done),
        .spi_master_rx   (spi_master_rx),
        .busy            (busy)
    );

    int          checks     = 0;
    int          failures   = 0;
    logic [10:0] exp_rsp[$];
    logic [9:0]  exp_spi[$];
    bit          mute       = 1'b0;
    int          start_count = 0;
    int          pulse_len  = 0;
    int          last_len   = 0;
    bit          prev_start = 1'b0;

    function automatic logic [7:0] slave_rx(input logic [1:0] s);
        case (s)
            2'd0:    return 8'hA5;
            2'd1:    return 8'h5A;
            2'd2:    return 8'h3C;
            default: return 8'hEE;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Response monitor
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=%0h expected=none", {rsp_sel, rsp_data, rsp_err});
            end else begin
                check("rsp", {21'd0, rsp_sel, rsp_data, rsp_err}, {21'd0, exp_rsp.pop_front()});
            end
        end
    end

    // SPI issue monitor
    initial forever begin
        @(negedge clk);
        if (spi_start === 1'b1) begin
            pulse_len++;
            if (!prev_start) begin
                start_count++;
                if (exp_spi.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spi_unexpected actual=%0h expected=none", {spi_slaveselect, spi_master_data});
                end else begin
                    check("spi_issue", {22'd0, spi_slaveselect, spi_master_data}, {22'd0, exp_spi.pop_front()});
                end
            end
            prev_start = 1'b1;
        end else begin
            if (prev_start) begin
                last_len  = pulse_len;
                pulse_len = 0;
            end
            prev_start = 1'b0;
        end
    end

    // Slave model: done after three cycles, held for two cycles
    initial forever begin
        @(posedge clk);
        #1;
        if (spi_start === 1'b1 && !mute) begin
            repeat (3) @(posedge clk);
            #1;
            spi_master_rx = slave_rx(spi_slaveselect);
            spi_done      = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            spi_done      = 1'b0;
            spi_master_rx = 8'h00;
        end
    end

    task automatic push_cmd(input logic [1:0] sel, input logic [7:0] data, input bit tmo, output bit saw_full);
        int n;
        n        = 0;
        saw_full = 1'b0;
        cmd_sel   = sel;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            saw_full = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=%0d expected=<200", n);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (sel == 2'd3) begin
            exp_rsp.push_back({sel, 8'h00, 1'b1});
        end else if (tmo) begin
            exp_spi.push_back({sel, data});
            exp_rsp.push_back({sel, 8'h00, 1'b1});
        end else begin
            exp_spi.push_back({sel, data});
            exp_rsp.push_back({sel, slave_rx(sel), 1'b0});
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || busy || rsp_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n < 2000, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=expired expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sf;
        bit any_full;
        int s;
        int n;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_sel       = 2'd0;
        cmd_data      = 8'h00;
        rsp_ready     = 1'b1;
        spi_done      = 1'b0;
        spi_master_rx = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_spi_out", {spi_slaveselect, spi_master_data}, 0);
        check("rst_rsp_out", {rsp_sel, rsp_data, rsp_err}, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);

        // single transfer
        push_cmd(2'd0, 8'hF0, 1'b0, sf);
        drain("t1_drain");

        // back-to-back transfers
        push_cmd(2'd0, 8'hF0, 1'b0, sf);
        push_cmd(2'd1, 8'hAA, 1'b0, sf);
        push_cmd(2'd2, 8'h55, 1'b0, sf);
        drain("t2_drain");

        // illegal select
        s = start_count;
        push_cmd(2'd3, 8'h12, 1'b0, sf);
        drain("t3_drain");
        check("illegal_no_start", start_count - s, 0);

        // timeout then a normal command
        mute = 1'b1;
        push_cmd(2'd2, 8'h77, 1'b1, sf);
        push_cmd(2'd1, 8'h0F, 1'b0, sf);
        n = 0;
        while (spi_start !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n = 0;
        while (spi_start === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        mute = 1'b0;
        @(negedge clk);
        #1;
        check("tmo_pulse_len", last_len, 16);
        drain("t4_drain");

        // response backpressure
        rsp_ready = 1'b0;
        s        = start_count;
        any_full = 1'b0;
        push_cmd(2'd0, 8'h11, 1'b0, sf); any_full |= sf;
        push_cmd(2'd1, 8'h22, 1'b0, sf); any_full |= sf;
        push_cmd(2'd2, 8'h33, 1'b0, sf); any_full |= sf;
        push_cmd(2'd0, 8'h44, 1'b0, sf); any_full |= sf;
        push_cmd(2'd1, 8'h55, 1'b0, sf); any_full |= sf;
        push_cmd(2'd2, 8'h66, 1'b0, sf); any_full |= sf;
        check("cmd_ready_fell", any_full, 1);
        repeat (80) @(posedge clk);
        #1;
        check("stall_starts", start_count - s, 5);
        check("stall_busy", busy, 1);
        check("stall_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        drain("t5_drain");

        // reset during ISSUE
        mute = 1'b1;
        push_cmd(2'd1, 8'h99, 1'b1, sf);
        n = 0;
        while (spi_start !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check("pre_rst_in_issue", spi_start, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_spi_start", spi_start, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_spi_out", {spi_slaveselect, spi_master_data}, 0);
        exp_rsp.delete();
        exp_spi.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mute  = 1'b0;
        @(posedge clk);
        #1;
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_busy", busy, 0);
        check("rel_rsp_valid", rsp_valid, 0);

        // recovery after reset
        push_cmd(2'd2, 8'hC3, 1'b0, sf);
        drain("t7_drain");
        check("spi_queue_empty", exp_spi.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 Parameter: CMD_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 Parameter: RSP_DEPTH, default 4, response FIFO entries (power of 2, >=2).
REQ-003 Parameter: TIMEOUT, default 1023, max cycles to wait for spi_done per transfer.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1 / cmd_ready  out  1  command handshake; transfer when both high.
REQ-007 cmd_sel  in  2  target slave (0..2; 3 is illegal).
REQ-008 cmd_data  in  8  byte for master to shift out on MOSI.
REQ-009 rsp_valid  out  1 / rsp_ready  in  1  response handshake; transfer when both high.
REQ-010 rsp_sel  out  2 / rsp_data  out  8 / rsp_err  out  1  slave echoed, byte received on MISO, error flag.
REQ-011 spi_start  out  1 / spi_slaveselect  out  2 / spi_master_data  out  8  drive the SPI top start, slaveselect, master_data.
REQ-012 spi_done  in  1 / spi_master_rx  in  8  SPI top done and master_rx.
REQ-013 busy  out  1  high whenever FSM not IDLE or command FIFO non-empty.

Function
REQ-014 Command FIFO: cmd_ready = not full; push on handshake; simultaneous push and pop when full is impossible (ready low); simultaneous push+pop otherwise keeps count.
REQ-015 FSM states IDLE, ISSUE, CAPTURE, RELEASE.
REQ-016 IDLE: if command FIFO non-empty, pop head into held registers (sel, data); sel==3 -> CAPTURE with err=1, rx=0x00, no SPI activity; else -> ISSUE.
REQ-017 ISSUE: spi_start=1, spi_slaveselect/spi_master_data = held values, stable for whole state; timeout counter increments each cycle.
REQ-018 ISSUE exit: spi_done==1 -> sample spi_master_rx same cycle, err=0, -> CAPTURE; counter reaches TIMEOUT first -> rx=0x00, err=1, -> CAPTURE.
REQ-019 CAPTURE: spi_start=0; push {sel, rx, err} into response FIFO when not full, then -> RELEASE; if full, hold in CAPTURE (no loss, no overwrite).
REQ-020 RELEASE: wait until spi_done==0, then -> IDLE; error/illegal entries skip wait when spi_done already 0.
REQ-021 spi_start high only in ISSUE; one-cycle minimum gap between consecutive spi_start pulses guaranteed.
REQ-022 Response FIFO: rsp_valid = not empty; head presented on rsp_sel/rsp_data/rsp_err; pop on handshake; push and pop in same cycle allowed at any occupancy including full-with-pop.
REQ-023 FIFO pointers wrap modulo depth; counts one bit wider than pointer.
REQ-024 Command order preserved end to end; exactly one response per accepted command.
REQ-025 Timeout counter width ceil(log2(TIMEOUT+1)); cleared on entry to ISSUE.

Reset
REQ-026 reset low asynchronously: FSM=IDLE, both FIFOs empty, cmd_ready=0 while asserted and 1 first cycle after release, rsp_valid=0, spi_start=0, spi_slaveselect=0, spi_master_data=0x00, rsp_* =0, busy=0.
REQ-027 reset mid-transfer drops in-flight and queued commands without response; spi_start falls immediately.

Structure
REQ-028 Shared package holds FSM state encoding, SEL_ILLEGAL=2'd3, and response record width constant (11 bits).
REQ-029 One sub-module, spi_seq_fifo (parameterised width/depth), instantiated twice for command and response queues.

Verification
REQ-030 Single cmd sel=0 data=0xF0, slave0 returns 0xA5 -> spi_slaveselect=0, spi_master_data=0xF0, one response {0,0xA5,err=0}.
REQ-031 Three back-to-back cmds (0,0xF0),(1,0xAA),(2,0x55) pushed in consecutive cycles -> three SPI transfers in order, responses 0xA5,0x5A,0x3C with sels 0,1,2.
REQ-032 cmd sel=3 data=0x12 -> no spi_start pulse, response {3,0x00,err=1}.
REQ-033 spi_done held 0 (TIMEOUT=15) -> spi_start drops after 16 cycles, response err=1 data=0x00, next command proceeds.
REQ-034 rsp_ready=0, push 6 cmds with depths 4 -> cmd_ready falls at full, FSM stalls in CAPTURE; release rsp_ready -> all 6 responses in order, none lost.
REQ-035 reset asserted during ISSUE -> spi_start=0 same cycle, rsp_valid=0, busy=0, cmd_ready=1 cycle after release.
